// File: rtl/hazard_unit.sv
// hazard_unit -- load-use / forwarding / flush control for the 5-stage RV32I core.
//
// The unit keeps a scoreboard of the instructions in EX and MEM: destination
// register plus op class (0 none, 1 ALU, 2 load). Using that scoreboard and the
// ID-stage decode fields it drives:
//   forward_ctrl_A/B   : ID operand source (0 regfile, 1 EX ALU, 2 MEM ALU, 3 MEM load)
//   forward_ctrl_ls    : the store now in MEM takes its data from the WB load result
//   stall_PC/IFID      : hold PC and IF/ID for a one-cycle load-use stall
//   flush_IFID/IDEX    : bubble IF/ID on a redirect, bubble ID/EX on a stall
//   stall_cnt          : saturating count of load-use stall cycles
// Inputs: clk, rst_n (async, active low), freeze, id_valid, rs1/rs2/rd addresses,
// rs1use/rs2use, hazard_optype (0 none, 1 ALU, 2 load, 3 store), redirect.

// Forward select for one ID operand against the EX/MEM scoreboard.
module hazard_fwd_sel (
   input  logic       use_rs,
   input  logic [4:0] rs,
   input  logic [4:0] ex_rd,
   input  logic [1:0] ex_op,
   input  logic [4:0] mem_rd,
   input  logic [1:0] mem_op,
   output logic       ex_ld_hit,
   output logic [1:0] sel
);
   logic ex_hit, mem_hit;

   assign ex_hit  = use_rs && (rs != 5'd0) && (rs == ex_rd)  && (ex_op  == 2'd1 || ex_op  == 2'd2);
   assign mem_hit = use_rs && (rs != 5'd0) && (rs == mem_rd) && (mem_op == 2'd1 || mem_op == 2'd2);
   assign ex_ld_hit = ex_hit && (ex_op == 2'd2);

   // EX has priority; an EX load hit selects the regfile because the stall
   // (or the late store-data path) covers it, so MEM must not be consulted.
   always_comb begin
      sel = 2'd0;
      if (ex_hit) begin
         if (ex_op == 2'd1) sel = 2'd1;
      end else if (mem_hit) begin
         sel = (mem_op == 2'd1) ? 2'd2 : 2'd3;
      end
   end
endmodule

module hazard_unit #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             freeze,
   input  logic             id_valid,
   input  logic [4:0]       rs1_addr,
   input  logic [4:0]       rs2_addr,
   input  logic [4:0]       rd_addr,
   input  logic             rs1use,
   input  logic             rs2use,
   input  logic [1:0]       hazard_optype,
   input  logic             redirect,
   output logic [1:0]       forward_ctrl_A,
   output logic [1:0]       forward_ctrl_B,
   output logic             forward_ctrl_ls,
   output logic             stall_PC,
   output logic             stall_IFID,
   output logic             flush_IFID,
   output logic             flush_IDEX,
   output logic [CNT_W-1:0] stall_cnt
);
   logic [4:0] ex_rd, mem_rd;
   logic [1:0] ex_op, mem_op;
   logic       ls_ex, ls_mem;

   logic [1:0][4:0] rs_addr;
   logic [1:0]      rs_use;
   logic [1:0][1:0] fsel;
   logic [1:0]      ex_ld;

   assign rs_addr = {rs2_addr, rs1_addr};
   assign rs_use  = {rs2use, rs1use};

   genvar g;
   for (g = 0; g < 2; g++) begin : g_opnd
      hazard_fwd_sel u_sel (
         .use_rs    (rs_use[g]),
         .rs        (rs_addr[g]),
         .ex_rd     (ex_rd),
         .ex_op     (ex_op),
         .mem_rd    (mem_rd),
         .mem_op    (mem_op),
         .ex_ld_hit (ex_ld[g]),
         .sel       (fsel[g])
      );
   end

   assign forward_ctrl_A  = fsel[0];
   assign forward_ctrl_B  = fsel[1];
   assign forward_ctrl_ls = ls_mem;

   // A store whose only EX-load dependency is its data operand need not stall:
   // the data is picked up from WB when the store reaches MEM.
   logic st_exc, ls_pend, load_stall, en;
   assign st_exc     = (hazard_optype == 2'd3) && ex_ld[1] && !ex_ld[0];
   assign ls_pend    = id_valid && st_exc;
   assign load_stall = id_valid && (ex_ld[0] || ex_ld[1]) && !st_exc;
   // rst_n in the gate keeps redirect from leaking a flush while in reset.
   assign en         = rst_n && !freeze;

   assign stall_PC   = en && load_stall;
   assign stall_IFID = en && load_stall;
   assign flush_IDEX = en && load_stall;
   assign flush_IFID = en && redirect && !load_stall;

   logic id_wr;
   assign id_wr = (hazard_optype == 2'd1 || hazard_optype == 2'd2) && (rd_addr != 5'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_rd     <= '0;
         ex_op     <= '0;
         mem_rd    <= '0;
         mem_op    <= '0;
         ls_ex     <= 1'b0;
         ls_mem    <= 1'b0;
         stall_cnt <= '0;
      end else if (!freeze) begin
         mem_rd <= ex_rd;
         mem_op <= ex_op;
         ls_mem <= ls_ex;
         if (load_stall || !id_valid) begin
            ex_rd <= '0;
            ex_op <= '0;
            ls_ex <= 1'b0;
         end else begin
            ex_rd <= rd_addr;
            ex_op <= id_wr ? hazard_optype : 2'd0;
            ls_ex <= ls_pend;
         end
         if (load_stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      end
   end
endmodule
